// File: rtl/board_setup_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_setup_sequencer_pkg
// Description : Shared board/piece encodings, canonical Banqi deck and the
//               setup sequencer state encoding. Also used by the game logic.
// Revision    : 1.0 - initial release
// ============================================================================
package board_setup_sequencer_pkg;

    // Square address {row[1:0], col[2:0]} and piece {color, type[2:0], state}
    localparam int ROW_W     = 2;
    localparam int COL_W     = 3;
    localparam int ADDR_W    = ROW_W + COL_W;
    localparam int TYPE_W    = 3;
    localparam int PIECE_W   = 1 + TYPE_W + 1;
    localparam int DECK_SIZE = 32;

    localparam logic [TYPE_W-1:0] PIECE_KING    = 3'b111;
    localparam logic [TYPE_W-1:0] PIECE_QUEEN   = 3'b110;
    localparam logic [TYPE_W-1:0] PIECE_BISHOP  = 3'b101;
    localparam logic [TYPE_W-1:0] PIECE_ROOK    = 3'b100;
    localparam logic [TYPE_W-1:0] PIECE_KNIGHT  = 3'b011;
    localparam logic [TYPE_W-1:0] PIECE_CANNON  = 3'b010;
    localparam logic [TYPE_W-1:0] PIECE_SOLDIER = 3'b001;

    localparam logic COLOR_RED       = 1'b0;
    localparam logic COLOR_BLACK     = 1'b1;
    localparam logic STATE_COVERED   = 1'b0;
    localparam logic STATE_UNCOVERED = 1'b1;

    // Galois feedback mask of the 16-bit move/shuffle LFSR
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_LOAD    = 3'd1,
        SEQ_SHUFFLE = 3'd2,
        SEQ_WRITE   = 3'd3,
        SEQ_DONE    = 3'd4
    } seq_state_t;

    // Canonical deck: upper half black, each half ordered KING..SOLDIER, all covered
    function automatic logic [PIECE_W-1:0] deck_piece(input logic [ADDR_W-1:0] k);
        logic [TYPE_W-1:0] t;
        case (k[3:0])
            4'd0:          t = PIECE_KING;
            4'd1,  4'd2:   t = PIECE_QUEEN;
            4'd3,  4'd4:   t = PIECE_BISHOP;
            4'd5,  4'd6:   t = PIECE_ROOK;
            4'd7,  4'd8:   t = PIECE_KNIGHT;
            4'd9,  4'd10:  t = PIECE_CANNON;
            default:       t = PIECE_SOLDIER;
        endcase
        return {k[4], t, STATE_COVERED};
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_setup_sequencer_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Galois LFSR (right shift), loads seed
//               while reset is low. Shared with the AI move randomiser.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import board_setup_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] r_lfsr;

    // Shift right every cycle, folding the dropped bit back through the taps
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_lfsr <= seed;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign out = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/board_setup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : board_setup_sequencer
// Description : Owns the board register write port. Passes game-logic writes
//               through when idle; on new_game builds, shuffles (Fisher-Yates
//               with LFSR draws and rejection) and writes a full Banqi deck.
// Revision    : 1.0 - initial release
// ============================================================================
module board_setup_sequencer
    import board_setup_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter bit          SHUFFLE_EN = 1'b1
)(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               new_game,
    input  logic [ADDR_W-1:0]  gl_addr,
    input  logic [PIECE_W-1:0] gl_piece,
    input  logic               gl_we,
    output logic [ADDR_W-1:0]  board_addr,
    output logic [PIECE_W-1:0] board_piece,
    output logic               board_we,
    output logic               busy,
    output logic               done,
    output logic               gl_drop
);

    seq_state_t         r_state;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W-1:0]  r_i;
    logic [ADDR_W-1:0]  r_k;
    logic [PIECE_W-1:0] r_deck [DECK_SIZE];

    logic [15:0]        w_lfsr;
    logic [ADDR_W-1:0]  w_j;
    logic               w_accept;
    logic               w_lfsr_unused;

    lfsr16 u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .seed  (SEED),
        .out   (w_lfsr)
    );

    // Only the low five bits form a draw; the rest feed other consumers
    assign w_j           = w_lfsr[ADDR_W-1:0];
    assign w_lfsr_unused = ^w_lfsr[15:ADDR_W];
    assign w_accept      = (w_j <= r_i);

    // Sequencer FSM with registered busy/done; rejected draws leave i unchanged
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= SEQ_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_i     <= '0;
            r_k     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (new_game) begin
                        r_state <= SEQ_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                SEQ_LOAD: begin
                    r_i     <= ADDR_W'(DECK_SIZE - 1);
                    r_k     <= '0;
                    r_state <= SHUFFLE_EN ? SEQ_SHUFFLE : SEQ_WRITE;
                end
                SEQ_SHUFFLE: begin
                    if (w_accept) begin
                        if (r_i == ADDR_W'(1)) begin
                            r_state <= SEQ_WRITE;
                        end else begin
                            r_i <= r_i - ADDR_W'(1);
                        end
                    end
                end
                SEQ_WRITE: begin
                    if (r_k == ADDR_W'(DECK_SIZE - 1)) begin
                        r_state <= SEQ_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_k <= r_k + ADDR_W'(1);
                    end
                end
                SEQ_DONE: begin
                    r_state <= SEQ_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= SEQ_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Deck storage: canonical load, then one swap per accepted draw (j==i is a no-op)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (r_state == SEQ_LOAD) begin
                for (int n = 0; n < DECK_SIZE; n++) begin
                    r_deck[n] <= deck_piece(ADDR_W'(n));
                end
            end else if (r_state == SEQ_SHUFFLE && w_accept) begin
                r_deck[r_i] <= r_deck[w_j];
                r_deck[w_j] <= r_deck[r_i];
            end
        end
    end

    // Write-port mux: zero-latency pass-through when idle, deck stream in WRITE
    always_comb begin
        board_addr  = '0;
        board_piece = '0;
        board_we    = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                board_addr  = gl_addr;
                board_piece = gl_piece;
                board_we    = gl_we;
            end
            SEQ_WRITE: begin
                board_addr  = r_k;
                board_piece = r_deck[r_k];
                board_we    = 1'b1;
            end
            default: ;
        endcase
        if (!RESET) begin
            board_we = 1'b0;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign gl_drop = r_busy & gl_we & RESET;

endmodule
`default_nettype wire

// File: tb/tb_board_setup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_setup_sequencer
// Description : Self-checking bench. One instance without shuffle, one with;
//               random game-logic traffic and new_game timing, checked against
//               a behavioural deck/shuffle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_setup_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n;
    logic [1:0]      ng;
    logic [1:0]      gw;
    logic [1:0][4:0] ga;
    logic [1:0][4:0] gp;
    wire  [1:0][4:0] ba;
    wire  [1:0][4:0] bp;
    wire  [1:0]      bw;
    wire  [1:0]      by;
    wire  [1:0]      dn;
    wire  [1:0]      gd;

    board_setup_sequencer #(.SEED(SEED), .SHUFFLE_EN(1'b0)) u_dut_ns (
        .CLK(clk), .RESET(rst_n[0]), .new_game(ng[0]),
        .gl_addr(ga[0]), .gl_piece(gp[0]), .gl_we(gw[0]),
        .board_addr(ba[0]), .board_piece(bp[0]), .board_we(bw[0]),
        .busy(by[0]), .done(dn[0]), .gl_drop(gd[0])
    );

    board_setup_sequencer #(.SEED(SEED), .SHUFFLE_EN(1'b1)) u_dut_sh (
        .CLK(clk), .RESET(rst_n[1]), .new_game(ng[1]),
        .gl_addr(ga[1]), .gl_piece(gp[1]), .gl_we(gw[1]),
        .board_addr(ba[1]), .board_piece(bp[1]), .board_we(bw[1]),
        .busy(by[1]), .done(dn[1]), .gl_drop(gd[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR per instance, reloaded whenever that instance is in reset
    logic [15:0] m_lfsr [2];
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            m_lfsr[s] <= !rst_n[s] ? SEED : lfsr_step(m_lfsr[s]);
        end
    end

    // Canonical piece from arithmetic on the index
    function automatic logic [4:0] model_piece(input int k);
        int idx;
        int t;
        idx = k % 16;
        if (idx == 0)       t = 7;
        else if (idx <= 10) t = 7 - (idx + 1) / 2;
        else                t = 1;
        return {(k >= 16) ? 1'b1 : 1'b0, 3'(t), 1'b0};
    endfunction

    logic [4:0] exp_deck [32];
    int         exp_shuf;
    logic [4:0] got_lay  [32];

    // Fisher-Yates with rejection; first draw is the value two cycles after new_game
    task automatic model_setup(input bit shuf, input logic [15:0] l_ng);
        logic [15:0] v;
        logic [4:0]  tmp;
        int i;
        int j;
        for (int k = 0; k < 32; k++) exp_deck[k] = model_piece(k);
        exp_shuf = 0;
        if (shuf) begin
            v = lfsr_step(lfsr_step(l_ng));
            i = 31;
            while (i >= 1 && exp_shuf < 5000) begin
                j = int'(v[4:0]);
                if (j <= i) begin
                    tmp         = exp_deck[i];
                    exp_deck[i] = exp_deck[j];
                    exp_deck[j] = tmp;
                    i--;
                end
                exp_shuf++;
                v = lfsr_step(v);
            end
        end
    endtask

    task automatic drive_gl(input int sel);
        gw[sel] = ($urandom_range(0, 1) == 1);
        ga[sel] = 5'($urandom);
        gp[sel] = 5'($urandom);
    endtask

    task automatic run_game(input int sel, input int ng_delay, input int abort_k);
        logic [15:0] l_ng;
        int          s;
        int          k;
        bit          exp_we;
        s = 0;
        for (int a = 0; a < 32; a++) got_lay[a] = 5'h1f;

        // Reset: board_we must stay low even with a game-logic write present
        rst_n[sel] = 1'b0; ng[sel] = 1'b0; gw[sel] = 1'b1;
        ga[sel] = 5'($urandom); gp[sel] = 5'($urandom);
        @(negedge clk); chk("rst_board_we", 32'(bw[sel]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_busy", 32'(by[sel]), 0);
        chk("rst_done", 32'(dn[sel]), 0);
        chk("rst_gl_drop", 32'(gd[sel]), 0);
        @(posedge clk); #1;
        rst_n[sel] = 1'b1;

        // Idle pass-through with random traffic
        for (int c = 0; c < ng_delay; c++) begin
            drive_gl(sel);
            @(negedge clk);
            chk("idle_we", 32'(bw[sel]), 32'(gw[sel]));
            if (gw[sel]) begin
                chk("idle_addr", 32'(ba[sel]), 32'(ga[sel]));
                chk("idle_piece", 32'(bp[sel]), 32'(gp[sel]));
            end
            chk("idle_drop", 32'(gd[sel]), 0);
            @(posedge clk); #1;
        end

        // new_game with a same-cycle game-logic write that must still pass
        ng[sel] = 1'b1; gw[sel] = 1'b1;
        ga[sel] = 5'($urandom); gp[sel] = 5'($urandom);
        @(negedge clk);
        chk("ng_pass_we", 32'(bw[sel]), 1);
        chk("ng_pass_addr", 32'(ba[sel]), 32'(ga[sel]));
        chk("ng_pass_piece", 32'(bp[sel]), 32'(gp[sel]));
        l_ng = m_lfsr[sel];
        model_setup(sel == 1, l_ng);
        s = exp_shuf;
        @(posedge clk); #1;
        ng[sel] = 1'b0;

        for (int n = 1; n <= 35 + s; n++) begin
            drive_gl(sel);
            ng[sel] = (n <= 34 + s) && (($urandom_range(0, 7) == 0) || (n == 7 + s));
            if (abort_k >= 0 && n == 2 + s + abort_k) begin
                rst_n[sel] = 1'b0;
                @(negedge clk);
                chk("abort_we", 32'(bw[sel]), 0);
                @(posedge clk); #1;
                rst_n[sel] = 1'b1; ng[sel] = 1'b0; gw[sel] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("abort_busy", 32'(by[sel]), 0);
                    chk("abort_done", 32'(dn[sel]), 0);
                    chk("abort_we_idle", 32'(bw[sel]), 0);
                    @(posedge clk); #1;
                end
                return;
            end
            @(negedge clk);
            if (n <= 34 + s) begin
                exp_we = (n >= 2 + s) && (n <= 33 + s);
                chk("busy", 32'(by[sel]), 1);
                chk("drop", 32'(gd[sel]), 32'(gw[sel]));
                chk("seq_we", 32'(bw[sel]), 32'(exp_we));
                chk("done", 32'(dn[sel]), 32'(n == 34 + s));
                if (exp_we && bw[sel]) begin
                    k = n - 2 - s;
                    chk("wr_addr", 32'(ba[sel]), 32'(k));
                    chk("wr_piece", 32'(bp[sel]), 32'(exp_deck[k]));
                    got_lay[ba[sel]] = bp[sel];
                end
            end else begin
                chk("post_busy", 32'(by[sel]), 0);
                chk("post_done", 32'(dn[sel]), 0);
                chk("post_we", 32'(bw[sel]), 32'(gw[sel]));
                chk("post_drop", 32'(gd[sel]), 0);
            end
            @(posedge clk); #1;
        end
        ng[sel] = 1'b0; gw[sel] = 1'b0;
    endtask

    // Deck composition from the rules: 1 KING, 2 of each officer, 5 SOLDIER per color
    task automatic check_composition();
        int cnt [2][8];
        int cov;
        cov = 0;
        for (int c = 0; c < 2; c++) for (int t = 0; t < 8; t++) cnt[c][t] = 0;
        for (int a = 0; a < 32; a++) begin
            cnt[got_lay[a][4]][got_lay[a][3:1]]++;
            cov += int'(got_lay[a][0]);
        end
        chk("all_covered", 32'(cov), 0);
        for (int c = 0; c < 2; c++) begin
            chk("cnt_king",    32'(cnt[c][7]), 1);
            chk("cnt_queen",   32'(cnt[c][6]), 2);
            chk("cnt_bishop",  32'(cnt[c][5]), 2);
            chk("cnt_rook",    32'(cnt[c][4]), 2);
            chk("cnt_knight",  32'(cnt[c][3]), 2);
            chk("cnt_cannon",  32'(cnt[c][2]), 2);
            chk("cnt_soldier", 32'(cnt[c][1]), 5);
        end
    endtask

    logic [4:0] lay_a [32];
    logic [4:0] mod_a [32];

    initial begin
        int same;
        int diff_got;
        int diff_exp;
        rst_n = 2'b00; ng = 2'b00; gw = 2'b00; ga = '0; gp = '0;
        repeat (2) @(posedge clk);
        #1;

        // Canonical order without shuffle, plus fixed squares
        run_game(0, 3, -1);
        chk("canon_addr0",  32'(got_lay[0]),  32'(5'b0_111_0));
        chk("canon_addr16", 32'(got_lay[16]), 32'(5'b1_111_0));
        chk("canon_addr31", 32'(got_lay[31]), 32'(5'b1_001_0));

        // Fixed IDLE pass-through pattern
        gw[0] = 1'b1; ga[0] = 5'b01_010; gp[0] = 5'b0_100_1;
        @(negedge clk);
        chk("pt_we", 32'(bw[0]), 1);
        chk("pt_addr", 32'(ba[0]), 32'(5'b01_010));
        chk("pt_piece", 32'(bp[0]), 32'(5'b0_100_1));
        chk("pt_drop", 32'(gd[0]), 0);
        @(posedge clk); #1;
        gw[0] = 1'b0;

        // Shuffled deck, determinism against new_game timing
        run_game(1, 5, -1);
        check_composition();
        for (int a = 0; a < 32; a++) begin lay_a[a] = got_lay[a]; mod_a[a] = exp_deck[a]; end
        run_game(1, 5, -1);
        same = 1;
        for (int a = 0; a < 32; a++) if (got_lay[a] !== lay_a[a]) same = 0;
        chk("determ_same", 32'(same), 1);
        run_game(1, 6, -1);
        check_composition();
        diff_got = 0; diff_exp = 0;
        for (int a = 0; a < 32; a++) begin
            if (got_lay[a] !== lay_a[a]) diff_got = 1;
            if (exp_deck[a] !== mod_a[a]) diff_exp = 1;
        end
        chk("determ_diff", 32'(diff_got), 32'(diff_exp));

        // Reset mid-WRITE, then recovery
        run_game(0, $urandom_range(1, 8), 10);
        run_game(0, 2, -1);
        chk("recover_addr31", 32'(got_lay[31]), 32'(5'b1_001_0));

        // Random new_game timing on the shuffled instance
        for (int r = 0; r < 3; r++) begin
            run_game(1, $urandom_range(1, 40), -1);
            check_composition();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_setup_sequencer.md
Name: board_setup_sequencer

Overview:
- Owns the single write port of the top-level 32-square board register (4 rows x 8 columns, 5-bit squares {color, type, state}).
- In normal play it passes game-logic writes straight through.
- On a new-game request it takes the port and generates a full Banqi deck: 16 red and 16 black pieces, all covered.
- It shuffles the deck with an LFSR-driven Fisher-Yates pass, then writes all 32 squares. During this sequence the game logic is held via busy.

Parameters:
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- SHUFFLE_EN, 1, 0 = skip the SHUFFLE state and write the canonical deck order (debug/verification).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- new_game  in  1  single-cycle pulse; starts a board setup
- gl_addr  in  5  game-logic write address {row[1:0], col[2:0]}
- gl_piece  in  5  game-logic write data
- gl_we  in  1  game-logic write enable
- board_addr  out  5  board register write address
- board_piece  out  5  board register write data
- board_we  out  1  board register write enable
- busy  out  1  setup in progress; holds the game logic in its initial state
- done  out  1  one-cycle pulse when setup completes
- gl_drop  out  1  pulses when a gl_we is discarded during busy

Behaviour:
- Reset (RESET low at posedge):
  - state=IDLE, busy=0, done=0, gl_drop=0, lfsr=SEED.
  - board_we is forced to 0 combinationally while RESET is low.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances every cycle in every state, so layout depends on new_game timing.
  - Draw j = lfsr[4:0].
- Canonical deck, index k:
  - color = k[4].
  - type by k[3:0]: 0 -> KING 3'b111; 1-2 -> QUEEN 110; 3-4 -> BISHOP 101; 5-6 -> ROOK 100; 7-8 -> KNIGHT 011; 9-10 -> CANNON 010; 11-15 -> SOLDIER 001.
  - state bit = 0 (covered).
- Internal deck: 32x5 register array.
- States:
  - IDLE:
    - board_* = gl_* combinationally (zero latency); busy=0.
    - new_game -> LOAD. A same-cycle gl write still passes through.
  - LOAD (1 cycle):
    - All 32 deck entries loaded from the canonical ROM; i=31.
    - -> SHUFFLE if SHUFFLE_EN, else -> WRITE with k=0.
  - SHUFFLE:
    - If j <= i: swap deck[i] and deck[j] (j==i is a no-op), then i--.
    - If j > i: reject and retry next cycle with i unchanged.
    - Swap at i==1 -> WRITE with k=0.
    - Duration is variable: 31 accepted draws.
  - WRITE:
    - board_addr=k, board_piece=deck[k], board_we=1.
    - k increments 0..31, one square per cycle, ascending, each address exactly once.
    - After k=31 -> DONE.
  - DONE: done=1 for one cycle, -> IDLE.
- busy = 1 in LOAD, SHUFFLE, WRITE and DONE.
- Minimum latency from new_game to done: 65 cycles with shuffle, 34 without.
- gl_we while busy:
  - The write is discarded and never reaches the board port.
  - gl_drop=1 in that same cycle (combinational).
- new_game while busy: ignored; no restart, no extra writes.
- board_addr and board_piece when board_we=0: don't-care, but driven (no X).
- RESET low mid-sequence:
  - Aborts to IDLE next cycle with no done pulse.
  - The board is left partially written; recovery is a new new_game.

Decomposition:
- Shared package (also used by game logic):
  - PIECE_* type codes, COLOR_RED/BLACK, STATE_COVERED/UNCOVERED.
  - Square address field widths.
  - Canonical-deck function deck_piece(k).
  - Sequencer state encoding.
- One sub-module, lfsr16 (CLK, RESET, seed, out[15:0]). Free-running, reused later for AI move randomisation.

Test Plan:
- SHUFFLE_EN=0, reset, pulse new_game:
  - busy=1 the next cycle, then exactly 32 writes at addr 0..31.
  - Data: addr0=5'b0_111_0, addr16=5'b1_111_0, addr31=5'b1_001_0.
  - done pulses once, 34 cycles after new_game; busy=0 afterwards.
- SHUFFLE_EN=1, SEED=16'hACE1, new_game:
  - 32 writes, addresses ascending and unique, all state bits 0.
  - Per color: 1 KING, 2 each of QUEEN/BISHOP/ROOK/KNIGHT/CANNON, 5 SOLDIER.
- IDLE pass-through: gl_we=1, gl_addr=5'b01_010, gl_piece=5'b0_100_1 -> board_we=1 with identical addr/piece in the same cycle; gl_drop=0.
- During WRITE:
  - gl_we=1 -> gl_drop=1 and board data still equals deck[k].
  - A second new_game -> still exactly 32 writes and a single done.
- RESET low at WRITE k=10 -> board_we=0 that cycle; next cycle IDLE, busy=0; done never pulses.
- Determinism: two runs with new_game issued 5 cycles after reset produce identical 32-square layouts. Issuing it 6 cycles after reset produces a different layout.
